// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: sequences RV32M multiplies through a fixed-latency multiplier, with a one-entry product cache
module mul_issue_ctrl #(
  parameter int MUL_LAT  = 3,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_rs1_i,
  input  logic [31:0] req_rs2_i,
  input  logic [4:0]  req_rd_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        mul_start_o,
  output logic [32:0] mul_a_o,
  output logic [32:0] mul_b_o,
  input  logic [65:0] mul_p_i
);
  localparam int CW = $clog2(MUL_LAT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
  state_e      state_q, state_d;
  logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d, wb_data_q, wb_data_d;
  logic [1:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        wbv_q, wbv_d, cv_q, cv_d;
  logic [65:0] ck_q, ck_d;
  logic [63:0] cp_q, cp_d;
  logic        idle, acc, hit, sa, sb;
  logic [1:0]  f3;
  logic [31:0] a, b;
  logic [65:0] key;
  logic        unused_p;
  function automatic logic [31:0] sel(input logic [63:0] p, input logic [1:0] f);
    return (f == 2'b00) ? p[31:0] : p[63:32];
  endfunction
  assign unused_p    = ^mul_p_i[65:64];
  assign idle        = (state_q == IDLE);
  assign f3          = idle ? req_funct3_i[1:0] : f3_q;
  assign a           = idle ? req_rs1_i : rs1_q;
  assign b           = idle ? req_rs2_i : rs2_q;
  assign sa          = (f3 != 2'b11);
  assign sb          = ~f3[1];
  assign key         = {a, b, sa, sb};
  assign acc         = idle & req_valid_i & ~req_funct3_i[2] & ~flush_i;
  assign hit         = CACHE_EN & cv_q & (ck_q == key);
  assign mul_a_o     = {sa & a[31], a};
  assign mul_b_o     = {sb & b[31], b};
  assign mul_start_o = acc & ~hit;
  assign stall_o     = acc | (state_q == WAIT);
  assign wb_valid_o  = wbv_q & ~flush_i;
  assign wb_rd_o     = wb_rd_q;
  assign wb_data_o   = wb_data_q;
  // next-state: accept/hit in IDLE, count and capture in WAIT, retire in DONE
  always_comb begin
    state_d   = state_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    wbv_d     = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    cv_d      = cv_q;
    ck_d      = ck_q;
    cp_d      = cp_q;
    case (state_q)
      IDLE: if (acc) begin
        rs1_d = req_rs1_i;
        rs2_d = req_rs2_i;
        f3_d  = req_funct3_i[1:0];
        rd_d  = req_rd_i;
        if (hit) begin
          wb_data_d = sel(cp_q, f3);
          wb_rd_d   = req_rd_i;
          wbv_d     = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d   = CW'(MUL_LAT);
          state_d = WAIT;
        end
      end
      WAIT: if (flush_i) begin
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          wb_data_d = sel(mul_p_i[63:0], f3_q);
          wb_rd_d   = rd_q;
          wbv_d     = 1'b1;
          cv_d      = 1'b1;
          ck_d      = key;
          cp_d      = mul_p_i[63:0];
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rs1_q     <= '0;
      rs2_q     <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      wbv_q     <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      cv_q      <= 1'b0;
      ck_q      <= '0;
      cp_q      <= '0;
    end else begin
      state_q   <= state_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      f3_q      <= f3_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      wbv_q     <= wbv_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      cv_q      <= cv_d;
      ck_q      <= ck_d;
      cp_q      <= cp_d;
    end
  end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: randomized check of mul_issue_ctrl against a behavioural multiply/cache model
module tb_mul_issue_ctrl;
  localparam int LAT = 3;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, flush = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_rs1 = '0, req_rs2 = '0;
  logic [4:0]  req_rd = '0;
  logic        stall, wb_valid, mul_start;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [32:0] mul_a, mul_b;
  logic [65:0] mul_p;
  logic signed [65:0] ea, eb, prod;
  logic [65:0] pipe [LAT];
  int total = 0, bad = 0;
  bit          cv = 0;
  logic [31:0] c1, c2;
  bit          csa, csb;
  logic [31:0] pool [4];

  mul_issue_ctrl #(.MUL_LAT(LAT), .CACHE_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_funct3_i(req_funct3),
    .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_rd_i(req_rd), .flush_i(flush),
    .stall_o(stall), .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .mul_start_o(mul_start), .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_p_i(mul_p)
  );

  always #5 clk = ~clk;

  // multiplier stand-in: product valid LAT edges after start, garbage otherwise
  assign ea    = $signed(mul_a);
  assign eb    = $signed(mul_b);
  assign prod  = ea * eb;
  assign mul_p = pipe[LAT-1];
  always_ff @(posedge clk) begin
    pipe[0] <= mul_start ? prod : 66'({$urandom(), $urandom(), $urandom()});
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint x, y, p;
    x = (f3 != 3) ? longint'($signed(a)) : longint'(a);
    y = (f3 < 2)  ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return (f3 == 0) ? p[31:0] : p[63:32];
  endfunction

  // one request from the IDLE accept cycle to retirement; fl<0 means no flush
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int fl);
    bit sa, sb, hit, killed;
    int lat, fc;
    sa  = (f3 != 3);
    sb  = (f3 < 2);
    hit = cv && c1 == a && c2 == b && csa == sa && csb == sb;
    lat = hit ? 1 : LAT + 1;
    fc  = (fl < 0) ? -1 : 1 + (fl % lat);
    killed = 0;
    req_valid = 1; req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_rd = rd;
    for (int c = 0; c <= lat; c++) begin
      flush = (c == fc);
      @(negedge clk);
      if (killed) begin
        check("kill_stall", stall, 0);
        check("kill_start", mul_start, 0);
        check("kill_wbv", wb_valid, 0);
      end else begin
        check("stall", stall, c < lat);
        check("start", mul_start, c == 0 && !hit);
        check("wbv", wb_valid, c == lat && !flush);
        if (c < lat) begin
          check("mul_a", mul_a, {sa & a[31], a});
          check("mul_b", mul_b, {sb & b[31], b});
        end
        if (c == lat && !flush) begin
          check("wb_rd", wb_rd, rd);
          check("wb_data", wb_data, ref_res(f3, a, b));
        end
        if (!hit && c == LAT && !flush) begin
          cv = 1; c1 = a; c2 = b; csa = sa; csb = sb;
        end
        if (flush && c >= 1 && c < lat) killed = 1;
      end
      @(posedge clk); #1;
      if (killed) req_valid = 0;
    end
    flush = 0;
    req_valid = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    pool = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0007, 32'h1234_5678};
    @(negedge clk);
    check("rst_wbv", wb_valid, 0);
    check("rst_wbrd", wb_rd, 0);
    check("rst_wbdata", wb_data, 0);
    check("rst_start", mul_start, 0);
    check("rst_stall", stall, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    run_op(3'd0, 32'd26, 32'd49, 5'd3, -1);
    check("mul_26x49", wb_data, 32'h4FA);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, -1);
    check("mulh_m1", wb_data, 32'd0);
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, -1);
    check("mul_m1_hit", wb_data, 32'd1);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, -1);
    check("mulhsu", wb_data, 32'hFFFF_FFFF);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, -1);
    check("mulhu", wb_data, 32'hFFFF_FFFE);
    run_op(3'd0, 32'd100, 32'd200, 5'd8, 1);
    run_op(3'd0, 32'd100, 32'd200, 5'd8, -1);
    // reset in the middle of a miss
    req_valid = 1; req_funct3 = 3'd0; req_rs1 = 32'd5; req_rs2 = 32'd9; req_rd = 5'd9;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1; req_valid = 0;
    #1;
    check("arst_wbv", wb_valid, 0);
    check("arst_wbrd", wb_rd, 0);
    check("arst_wbdata", wb_data, 0);
    check("arst_start", mul_start, 0);
    check("arst_stall", stall, 0);
    cv = 0;
    @(posedge clk); #1;
    rst = 0;
    run_op(3'd0, 32'd7, 32'd6, 5'd10, -1);
    check("mul_7x6", wb_data, 32'd42);
    // funct3 1xx is not ours
    for (int f = 4; f < 8; f++) begin
      req_valid = 1; req_funct3 = 3'(f); req_rs1 = 32'd3; req_rs2 = 32'd4;
      @(negedge clk);
      check("div_stall", stall, 0);
      check("div_start", mul_start, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("div_wbv", wb_valid, 0);
      @(posedge clk); #1;
    end
    req_valid = 0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        @(posedge clk); #1;
      end
      run_op(3'($urandom_range(0, 3)), pool[$urandom_range(0, 3)],
             ($urandom_range(0, 3) == 0) ? $urandom() : pool[$urandom_range(0, 3)],
             5'($urandom()), ($urandom_range(0, 9) < 2) ? int'($urandom_range(0, 7)) : -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
